pri_irq_ctrl: RTL and testbench

- Interrupt front-end built around the 4-bit priority encoder (pri_enc).
- Captures rising edges on four request lines into sticky pending bits and applies a per-line mask.
- Presents a held snapshot on the encoder's d input and consumes the encoder's q/v result.
- Raises one interrupt at a time toward the CPU, with ack handshake, pending-bit clear and ack timeout.

---
 rtl/pri_irq_ctrl.sv | 73 +++++++
 tb/tb_pri_irq_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pri_irq_ctrl.sv
// pri_irq_ctrl: edge-capturing interrupt front-end driving an external registered priority encoder
module pri_irq_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] mask_i,
  output logic [NUM_REQ-1:0] d_o,
  input  logic [IDX_W-1:0]   q_i,
  input  logic               v_i,
  output logic               irq_o,
  output logic [IDX_W-1:0]   irq_id_o,
  input  logic               ack_i,
  output logic [NUM_REQ-1:0] pending_o,
  output logic               timeout_err_o
);
  typedef enum logic [1:0] {IDLE, LOAD, SAMPLE, ASSERT} state_e;
  state_e state_q, state_d;
  logic [NUM_REQ-1:0] req_q, pending_q, pending_d, d_q, d_d, elig, clr;
  logic [IDX_W-1:0] id_q, id_d;
  logic [7:0] cnt_q, cnt_d;
  logic irq_q, irq_d, err_q, err_d, tmo, done;
  assign elig = pending_q & ~mask_i;
  assign tmo  = state_q == ASSERT && !ack_i && cnt_q == 8'(ACK_TIMEOUT - 1);
  assign done = state_q == ASSERT && (ack_i || tmo);
  // state register
  always_ff @(posedge clk_i)
    state_q <= rst_i ? IDLE : state_d;
  // next-state logic
  always_comb
    state_d = state_q == IDLE   ? (|elig ? LOAD : IDLE) :
              state_q == LOAD   ? SAMPLE :
              state_q == SAMPLE ? (v_i ? ASSERT : IDLE) :
              (done ? IDLE : ASSERT);
  // datapath next values; a new edge beats a same-edge clear of its pending bit
  always_comb begin
    clr = '0;
    clr[id_q] = done;
    pending_d = (pending_q & ~clr) | (req_i & ~req_q);
    d_d = state_q == IDLE ? elig : ((state_q == SAMPLE && !v_i) || done) ? '0 : d_q;
    irq_d = state_q == SAMPLE ? v_i : (done ? 1'b0 : irq_q);
    id_d = (state_q == SAMPLE && v_i) ? q_i : id_q;
    cnt_d = state_q == SAMPLE ? 8'd0 : state_q == ASSERT ? cnt_q + 8'd1 : cnt_q;
    err_d = err_q | tmo;
  end
  // datapath registers; req_q tracks req through reset so held lines raise no event
  always_ff @(posedge clk_i) begin
    req_q <= req_i;
    if (rst_i) begin
      pending_q <= '0;
      d_q <= '0;
      irq_q <= 1'b0;
      id_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      d_q <= d_d;
      irq_q <= irq_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign d_o = d_q;
  assign irq_o = irq_q;
  assign irq_id_o = id_q;
  assign pending_o = pending_q;
  assign timeout_err_o = err_q;
endmodule

// File: tb/tb_pri_irq_ctrl.sv
// tb_pri_irq_ctrl: vector table, corner sequences and randomized run against a behavioural model
module tb_pri_irq_ctrl;
  logic clk = 0, rst = 0, ack = 0, v, irq, err;
  logic [3:0] req = 0, mask = 0, d, pending;
  logic [1:0] q, id;
  int errors = 0, checks = 0;

  pri_irq_ctrl dut (.clk_i(clk), .rst_i(rst), .req_i(req), .mask_i(mask), .d_o(d), .q_i(q),
                    .v_i(v), .irq_o(irq), .irq_id_o(id), .ack_i(ack), .pending_o(pending),
                    .timeout_err_o(err));

  always #5 clk = ~clk;

  function automatic logic [1:0] top(input logic [3:0] x);
    logic [1:0] r = 0;
    for (int i = 0; i < 4; i++) if (x[i]) r = 2'(i);
    return r;
  endfunction

  // external encoder: registered, highest set bit wins
  always_ff @(posedge clk) begin
    q <= top(d);
    v <= |d;
  end

  // behavioural model: countdown to irq, age of the irq in edges
  logic [3:0] m_pend, m_prev, m_snap, m_d;
  logic [1:0] m_id;
  logic m_irq, m_err;
  int m_cd, m_age;

  task automatic model();
    logic [3:0] clr = 0;
    logic drop = 0;
    if (rst) begin
      m_pend = 0; m_d = 0; m_irq = 0; m_id = 0; m_err = 0; m_cd = 0; m_age = 0;
    end else begin
      if (m_irq) begin
        if (ack) drop = 1;
        else begin
          m_age++;
          if (m_age == 16) begin drop = 1; m_err = 1; end
        end
      end
      if (drop) begin
        clr[m_id] = 1; m_irq = 0; m_d = 0;
      end else if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) begin m_irq = 1; m_id = top(m_snap); m_age = 0; end
      end else if (!m_irq) begin
        m_snap = m_pend & ~mask;
        m_d = m_snap;
        if (m_snap != 0) m_cd = 2;
      end
      m_pend = (m_pend & ~clr) | (req & ~m_prev);
    end
    m_prev = req;
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] mk, input logic a);
    @(negedge clk);
    rst = r; req = rq; mask = mk; ack = a;
    @(posedge clk);
    model();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic e_irq, input logic [1:0] e_id,
                         input logic [3:0] e_pend, input logic [3:0] e_d, input logic e_err);
    chk({name, ".irq"}, 32'(irq), 32'(e_irq));
    if (e_irq) chk({name, ".id"}, 32'(id), 32'(e_id));
    chk({name, ".pend"}, 32'(pending), 32'(e_pend));
    chk({name, ".d"}, 32'(d), 32'(e_d));
    chk({name, ".err"}, 32'(err), 32'(e_err));
  endtask

  typedef struct {
    logic r; logic [3:0] rq, mk; logic a;
    logic e_irq; logic [1:0] e_id; logic [3:0] e_pend, e_d; logic e_err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl = '{
      '{1, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0},
      '{0, 4'b0001, 4'b0000, 0, 0, 0, 4'b0001, 4'b0000, 0},
      '{0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0001, 4'b0001, 0},
      '{0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0001, 4'b0001, 0},
      '{0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0001, 4'b0001, 0},
      '{0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0},
      '{0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0},
      '{0, 4'b1001, 4'b0000, 0, 0, 0, 4'b1001, 4'b0000, 0},
      '{0, 4'b1001, 4'b0000, 0, 0, 0, 4'b1001, 4'b1001, 0},
      '{0, 4'b1001, 4'b0000, 0, 0, 0, 4'b1001, 4'b1001, 0},
      '{0, 4'b1001, 4'b0000, 0, 1, 3, 4'b1001, 4'b1001, 0},
      '{0, 4'b1001, 4'b0000, 1, 0, 0, 4'b0001, 4'b0000, 0},
      '{0, 4'b1001, 4'b0000, 0, 0, 0, 4'b0001, 4'b0001, 0},
      '{0, 4'b1001, 4'b0000, 0, 0, 0, 4'b0001, 4'b0001, 0},
      '{0, 4'b1001, 4'b0000, 0, 1, 0, 4'b0001, 4'b0001, 0},
      '{0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0},
      '{0, 4'b1010, 4'b1000, 0, 0, 0, 4'b1010, 4'b0000, 0},
      '{0, 4'b1010, 4'b1000, 0, 0, 0, 4'b1010, 4'b0010, 0},
      '{0, 4'b1010, 4'b1000, 0, 0, 0, 4'b1010, 4'b0010, 0},
      '{0, 4'b1010, 4'b1000, 0, 1, 1, 4'b1010, 4'b0010, 0},
      '{0, 4'b1010, 4'b0000, 1, 0, 0, 4'b1000, 4'b0000, 0},
      '{0, 4'b1010, 4'b0000, 0, 0, 0, 4'b1000, 4'b1000, 0},
      '{0, 4'b1010, 4'b0000, 0, 0, 0, 4'b1000, 4'b1000, 0},
      '{0, 4'b1010, 4'b0000, 0, 1, 3, 4'b1000, 4'b1000, 0},
      '{0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0}
    };
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].rq, tbl[i].mk, tbl[i].a);
      chk_out($sformatf("vec%0d", i), tbl[i].e_irq, tbl[i].e_id, tbl[i].e_pend, tbl[i].e_d, tbl[i].e_err);
    end

    // ack timeout: drop on the 16th edge without ack, error is sticky
    step(1, 0, 0, 0);
    step(0, 4'b0100, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk_out("tmo.rise", 1, 2, 4'b0100, 4'b0100, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0);
    chk_out("tmo.edge15", 1, 2, 4'b0100, 4'b0100, 0);
    step(0, 0, 0, 0);
    chk_out("tmo.drop", 0, 0, 4'b0000, 4'b0000, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    chk_out("tmo.sticky", 0, 0, 4'b0000, 4'b0000, 1);

    // ack landing on the timeout edge wins
    step(1, 0, 0, 0);
    step(0, 4'b0100, 0, 0);
    for (int i = 0; i < 18; i++) step(0, 0, 0, 0);
    chk_out("ack16.pre", 1, 2, 4'b0100, 4'b0100, 0);
    step(0, 0, 0, 1);
    chk_out("ack16.drop", 0, 0, 4'b0000, 4'b0000, 0);

    // new edge on the ack edge keeps the pending bit and re-raises the irq
    step(1, 0, 0, 0);
    step(0, 4'b0100, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk_out("coll.rise", 1, 2, 4'b0100, 4'b0100, 0);
    step(0, 4'b0100, 0, 1);
    chk_out("coll.ack", 0, 0, 4'b0100, 4'b0000, 0);
    step(0, 4'b0100, 0, 0); step(0, 4'b0100, 0, 0);
    chk("coll.wait", 32'(irq), 0);
    step(0, 4'b0100, 0, 0);
    chk_out("coll.again", 1, 2, 4'b0100, 4'b0100, 0);

    // reset mid-handshake with the request held high
    step(1, 4'b0100, 0, 0);
    chk_out("rst.mid", 0, 0, 4'b0000, 4'b0000, 0);
    for (int i = 0; i < 6; i++) step(0, 4'b0100, 0, 0);
    chk_out("rst.held", 0, 0, 4'b0000, 4'b0000, 0);
    step(0, 0, 0, 0);
    step(0, 4'b0100, 0, 0);
    chk("rst.edge", 32'(pending), 32'(4'b0100));
    step(0, 4'b0100, 0, 0); step(0, 4'b0100, 0, 0); step(0, 4'b0100, 0, 0);
    chk_out("rst.irq", 1, 2, 4'b0100, 4'b0100, 0);

    // randomized run against the model
    step(1, 0, 0, 0);
    for (int n = 0; n < 2000; n++) begin
      logic [3:0] rq = req, mk = mask;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      if ($urandom_range(0, 15) == 0) mk = 4'($urandom);
      step($urandom_range(0, 399) == 0, rq, mk, $urandom_range(0, 11) == 0);
      chk("rand", {d, irq, irq ? id : 2'b0, pending, err},
                  {m_d, m_irq, m_irq ? m_id : 2'b0, m_pend, m_err});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
